hpm_snapshot_streamer: RTL and testbench



---
 rtl/hpm_stream_pkg.sv | 37 +++
 rtl/hpm_snapshot_streamer_if.sv | 12 +
 rtl/hpm_pkt_serializer.sv | 86 ++++++++
 rtl/hpm_snapshot_streamer.sv | 169 ++++++++++++++++
 tb/tb_hpm_snapshot_streamer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hpm_stream_pkg.sv
// Shared constants, state encoding and header helper for the HPM snapshot streamer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hpm_stream_pkg;

  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

  localparam int PKT_WORDS = 24;
  localparam int NUM_CNT   = 11;
  localparam int IDX_W     = 5;

  // Sampled counter indices in packet order: HPM0, then HPM2..HPM11.
  localparam logic [NUM_CNT-1:0][4:0] CNT_IDX = {5'd11, 5'd10, 5'd9, 5'd8, 5'd7, 5'd6,
                                                 5'd5, 5'd4, 5'd3, 5'd2, 5'd0};

  // Header word field offsets.
  localparam int HDR_CNT_LSB  = 0;
  localparam int HDR_DROP_LSB = 8;
  localparam int HDR_SEQ_LSB  = 16;

  // FSM state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ARMED = 2'd1;
  localparam state_t ST_SEND  = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

  function automatic logic [31:0] make_hdr(input logic [15:0] seq, input logic [7:0] drop);
    logic [31:0] hdr;
    hdr = '0;
    hdr[HDR_SEQ_LSB +: 16] = seq;
    hdr[HDR_DROP_LSB +: 8] = drop;
    hdr[HDR_CNT_LSB +: 8]  = 8'(NUM_CNT);
    return hdr;
  endfunction

endpackage

// File: rtl/hpm_snapshot_streamer_if.sv
// 32-bit valid/ready word stream with end-of-packet marker.
// Latency: n/a (wiring only).
// Backpressure: word moves when tx_valid && tx_ready; master holds data while stalled.
interface hpm_snapshot_streamer_if;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_last;
  logic        tx_ready;

  modport master (output tx_valid, output tx_data, output tx_last, input tx_ready);
  modport slave  (input tx_valid, input tx_data, input tx_last, output tx_ready);
endinterface

// File: rtl/hpm_pkt_serializer.sv
// Snapshot register bank plus word sequencer that streams one 24-word packet per capture.
// Latency: tx_valid rises the cycle after i_capture; one word per cycle with tx_ready high.
// Backpressure: word index and bank freeze while tx_ready is low, so tx_data/tx_last stay stable.
module hpm_pkt_serializer
  import hpm_stream_pkg::*;
(
  input  logic                      clk_h,
  input  logic                      rst_h,
  input  logic                      i_capture,
  input  logic [31:0]               i_hdr,
  input  logic [31:0]               i_stamp,
  input  logic [NUM_CNT-1:0][63:0]  i_cnt,
  hpm_snapshot_streamer_if.master   tx,
  output logic                      o_first_acc,
  output logic                      o_last_acc
);

  logic                     r_vld;
  logic [IDX_W-1:0]         r_idx;
  logic [31:0]              r_hdr;
  logic [31:0]              r_stamp;
  logic [NUM_CNT-1:0][63:0] r_cnt;

  logic                     w_acc;
  logic                     w_is_last;
  logic [3:0]               w_pair;
  logic [31:0]              w_word;

  assign w_acc     = r_vld && tx.tx_ready;
  assign w_is_last = (r_idx == IDX_W'(PKT_WORDS - 1));
  // Words 2..23 are lo/hi pairs, so the counter slot is idx/2 - 1.
  assign w_pair    = r_idx[4:1] - 4'd1;

  // Word sequencer: start on capture, advance on handshake, stop after the last word.
  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      r_vld <= 1'b0;
      r_idx <= '0;
    end else if (i_capture) begin
      r_vld <= 1'b1;
      r_idx <= '0;
    end else if (w_acc) begin
      if (w_is_last) begin
        r_vld <= 1'b0;
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  // Snapshot bank: loaded only on capture, held for the whole packet.
  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      r_hdr   <= '0;
      r_stamp <= '0;
      r_cnt   <= '0;
    end else if (i_capture) begin
      r_hdr   <= i_hdr;
      r_stamp <= i_stamp;
      r_cnt   <= i_cnt;
    end
  end

  // Word select from the frozen bank.
  always_comb begin
    w_word = '0;
    if (r_idx == IDX_W'(0)) begin
      w_word = r_hdr;
    end else if (r_idx == IDX_W'(1)) begin
      w_word = r_stamp;
    end else if (r_idx[0]) begin
      w_word = r_cnt[w_pair][63:32];
    end else begin
      w_word = r_cnt[w_pair][31:0];
    end
  end

  assign tx.tx_valid = r_vld;
  assign tx.tx_data  = w_word;
  assign tx.tx_last  = r_vld && w_is_last;

  assign o_first_acc = w_acc && (r_idx == IDX_W'(0));
  assign o_last_acc  = w_acc && w_is_last;

endmodule

// File: rtl/hpm_snapshot_streamer.sv
// Watches mcountinhibit writes and streams periodic HPM snapshots as 24-word packets.
// Latency: capture on the timer tick (or disable), first word valid the next cycle.
// Backpressure: tx_ready stalls the packet; ticks that land during a packet are counted as drops.
module hpm_snapshot_streamer
  import hpm_stream_pkg::*;
#(
  parameter logic [11:0] CSR_ADDR      = CSR_MCOUNTINHIBIT,
  parameter int          SAMPLE_PERIOD = 1024,
  parameter int          DROP_W        = 8
) (
  input  logic                    clk_h,
  input  logic                    rst_h,
  input  logic                    csr_we,
  input  logic [11:0]             csr_add,
  input  logic [31:0]             csr_data,
  input  logic [31:0][63:0]       HPM,
  hpm_snapshot_streamer_if.master tx,
  output logic                    active,
  output logic                    dropped_sat
);

  localparam logic [15:0]       TIMER_MAX = 16'(SAMPLE_PERIOD - 1);
  localparam logic [DROP_W-1:0] DROP_MAX  = '1;

  state_t              r_state;
  logic [15:0]         r_timer;
  logic [31:0]         r_stamp;
  logic [15:0]         r_seq;
  logic [DROP_W-1:0]   r_drop;
  logic [DROP_W-1:0]   r_drop_sent;
  logic                r_final;
  logic                r_pend_final;

  logic                     w_enable;
  logic                     w_disable;
  logic                     w_tick;
  logic                     w_tick_send;
  logic                     w_capture;
  logic                     w_first_acc;
  logic                     w_last_acc;
  logic [DROP_W-1:0]        w_drop_base;
  logic [31:0]              w_hdr;
  logic [NUM_CNT-1:0][63:0] w_cnt;
  logic                     w_unused_hpm;

  assign w_enable    = csr_we && (csr_add == CSR_ADDR) && (csr_data == 32'h0000_0000);
  assign w_disable   = csr_we && (csr_add == CSR_ADDR) && (csr_data == 32'hFFFF_FFFF);
  assign w_tick      = ((r_state == ST_ARMED) || (r_state == ST_SEND)) && (r_timer == TIMER_MAX);
  assign w_tick_send = w_tick && (r_state == ST_SEND);
  assign w_capture   = ((r_state == ST_ARMED) && (w_tick || w_disable)) || (r_state == ST_DRAIN);

  // Only the count actually reported in w0 is removed on its handshake, so ticks
  // that land while w0 is stalled carry into the next packet instead of vanishing.
  assign w_drop_base = w_first_acc ? (r_drop - r_drop_sent) : r_drop;
  assign w_hdr       = make_hdr(r_seq, 8'(r_drop));

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    assign w_cnt[k] = HPM[CNT_IDX[k]];
  end
  assign w_unused_hpm = ^{HPM[1], HPM[31:12]};

  // Stamp and sample timer: cleared on enable, free-running while active.
  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      r_stamp <= '0;
      r_timer <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_enable) begin
        r_stamp <= '0;
        r_timer <= '0;
      end
    end else begin
      r_stamp <= r_stamp + 32'd1;
      r_timer <= (r_timer == TIMER_MAX) ? 16'd0 : r_timer + 16'd1;
    end
  end

  // Saturating drop counter and the value frozen into the pending header.
  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      r_drop      <= '0;
      r_drop_sent <= '0;
    end else begin
      if (w_capture) begin
        r_drop_sent <= r_drop;
      end
      if (r_state == ST_IDLE) begin
        if (w_enable) begin
          r_drop <= '0;
        end
      end else if (w_first_acc || w_tick_send) begin
        r_drop <= (w_tick_send && (w_drop_base != DROP_MAX)) ? w_drop_base + DROP_W'(1)
                                                             : w_drop_base;
      end
    end
  end

  // Packet sequence number, advanced on each completed packet.
  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      r_seq <= '0;
    end else if (w_last_acc) begin
      r_seq <= r_seq + 16'd1;
    end
  end

  // Control FSM with final/pending-final tracking for a clean shutdown.
  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      r_state      <= ST_IDLE;
      r_final      <= 1'b0;
      r_pend_final <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_enable) begin
            r_state      <= ST_ARMED;
            r_final      <= 1'b0;
            r_pend_final <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (w_tick || w_disable) begin
            r_state <= ST_SEND;
            r_final <= w_disable;
          end
        end
        ST_SEND: begin
          if (w_disable && !r_final) begin
            r_pend_final <= 1'b1;
          end
          if (w_last_acc) begin
            if (r_final) begin
              r_state <= ST_IDLE;
            end else if (r_pend_final || w_disable) begin
              r_state <= ST_DRAIN;
            end else begin
              r_state <= ST_ARMED;
            end
          end
        end
        ST_DRAIN: begin
          r_state      <= ST_SEND;
          r_final      <= 1'b1;
          r_pend_final <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign active      = (r_state != ST_IDLE);
  assign dropped_sat = (r_drop == DROP_MAX);

  hpm_pkt_serializer u_ser (
    .clk_h       (clk_h),
    .rst_h       (rst_h),
    .i_capture   (w_capture),
    .i_hdr       (w_hdr),
    .i_stamp     (r_stamp),
    .i_cnt       (w_cnt),
    .tx          (tx),
    .o_first_acc (w_first_acc),
    .o_last_acc  (w_last_acc)
  );

endmodule

// File: tb/tb_hpm_snapshot_streamer.sv
// Directed bench for hpm_snapshot_streamer with SAMPLE_PERIOD=16.
// Edge Ek counts posedges after the enable edge E0; stamp and timer after Ek equal k (timer mod 16).
// Packets are 24 words, so with ready high every tick at 32n lands in SEND and is a drop.
module tb_hpm_snapshot_streamer;

  logic              clk_h = 1'b0;
  logic              rst_h;
  logic              csr_we;
  logic [11:0]       csr_add;
  logic [31:0]       csr_data;
  logic [31:0][63:0] HPM;
  logic              active;
  logic              dropped_sat;

  int checks   = 0;
  int failures = 0;

  logic [31:0] pkt [24];
  int          nlast;
  int          last_pos;

  hpm_snapshot_streamer_if tx_if ();

  hpm_snapshot_streamer #(
    .CSR_ADDR      (12'h320),
    .SAMPLE_PERIOD (16),
    .DROP_W        (8)
  ) dut (
    .clk_h       (clk_h),
    .rst_h       (rst_h),
    .csr_we      (csr_we),
    .csr_add     (csr_add),
    .csr_data    (csr_data),
    .HPM         (HPM),
    .tx          (tx_if),
    .active      (active),
    .dropped_sat (dropped_sat)
  );

  always #5 clk_h = ~clk_h;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_h);
      #1;
    end
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_we   = 1'b1;
    csr_add  = addr;
    csr_data = data;
    step(1);
    csr_we   = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!tx_if.tx_valid && n < max) begin
      step(1);
      n++;
    end
  endtask

  // Collect one packet with ready high; optionally issue a disable while word dis_at is shown.
  task automatic get_pkt(input int dis_at);
    tx_if.tx_ready = 1'b1;
    nlast    = 0;
    last_pos = -1;
    for (int i = 0; i < 24; i++) begin
      int n;
      n = 0;
      while (!tx_if.tx_valid && n < 50) begin
        step(1);
        n++;
      end
      if (!tx_if.tx_valid) begin
        chk("pkt_word_timeout", 32'(tx_if.tx_valid), 32'd1);
        return;
      end
      pkt[i] = tx_if.tx_data;
      if (tx_if.tx_last) begin
        nlast++;
        last_pos = i;
      end
      if (i == dis_at) begin
        csr_we   = 1'b1;
        csr_add  = 12'h320;
        csr_data = 32'hFFFF_FFFF;
      end
      step(1);
      csr_we = 1'b0;
    end
  endtask

  initial begin
    int n;
    int bad;
    logic [31:0] hold;

    rst_h = 1'b0;
    csr_we = 1'b0;
    csr_add = '0;
    csr_data = '0;
    tx_if.tx_ready = 1'b0;
    for (int k = 0; k < 32; k++) begin
      HPM[k] = {32'hC0DE_0000 | 32'(k), 32'h0000_1000 | 32'(k)};
    end
    HPM[2] = 64'h0000_0001_DEAD_BEEF;

    // Reset state
    step(3);
    chk("rst_valid", 32'(tx_if.tx_valid), 32'd0);
    chk("rst_last", 32'(tx_if.tx_last), 32'd0);
    chk("rst_data", tx_if.tx_data, 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_dropped_sat", 32'(dropped_sat), 32'd0);
    rst_h = 1'b1;
    step(1);

    // Non-matching writes are ignored
    csr_write(12'h320, 32'h0000_0005);
    chk("ignore_data", 32'(active), 32'd0);
    csr_write(12'h321, 32'h0000_0000);
    chk("ignore_addr", 32'(active), 32'd0);

    // Enable (E0); first tick at E16 captures stamp 15
    csr_write(12'h320, 32'h0000_0000);
    chk("en_active", 32'(active), 32'd1);
    tx_if.tx_ready = 1'b1;
    wait_valid(40, n);
    chk("p0_latency", n, 16);
    get_pkt(-1);
    chk("p0_w0", pkt[0], 32'h0000_000B);
    chk("p0_w1", pkt[1], 32'd15);
    chk("p0_w2_hpm0_lo", pkt[2], 32'h0000_1000);
    chk("p0_w3_hpm0_hi", pkt[3], 32'hC0DE_0000);
    chk("p0_w4_hpm2_lo", pkt[4], 32'hDEAD_BEEF);
    chk("p0_w5_hpm2_hi", pkt[5], 32'h0000_0001);
    chk("p0_w22_hpm11_lo", pkt[22], 32'h0000_100B);
    chk("p0_w23_hpm11_hi", pkt[23], 32'hC0DE_000B);
    chk("p0_nlast", nlast, 1);
    chk("p0_last_pos", last_pos, 23);

    // P1: tick at E32 fell inside P0 -> drop 1; capture at E48, stamp 47
    wait_valid(40, n);
    chk("p1_latency", n, 8);
    get_pkt(-1);
    chk("p1_w0", pkt[0], 32'h0001_010B);
    chk("p1_w1", pkt[1], 32'd47);

    // P2: captured at E80 (drop 1 from E64), stalled 36 cycles
    tx_if.tx_ready = 1'b0;
    wait_valid(40, n);
    chk("p2_latency", n, 8);
    chk("p2_stalled_w0", tx_if.tx_data, 32'h0002_010B);
    hold = tx_if.tx_data;
    bad  = 0;
    repeat (36) begin
      step(1);
      if (!tx_if.tx_valid || tx_if.tx_data !== hold || tx_if.tx_last !== 1'b0) bad++;
    end
    chk("stall_stable", bad, 0);
    chk("stall_dropped_sat", 32'(dropped_sat), 32'd0);
    get_pkt(-1);
    chk("p2_w0", pkt[0], 32'h0002_010B);
    chk("p2_w1", pkt[1], 32'd79);
    chk("p2_last_pos", last_pos, 23);

    // P3: drops E96,E112 during stall (-1 reported), E128 -> 3; disable at word 10
    wait_valid(40, n);
    chk("p3_latency", n, 4);
    get_pkt(10);
    chk("p3_w0", pkt[0], 32'h0003_030B);
    chk("p3_w1", pkt[1], 32'd143);
    chk("drain_active", 32'(active), 32'd1);
    chk("drain_valid", 32'(tx_if.tx_valid), 32'd0);

    // P4: final packet captured in DRAIN at E169 (stamp 168, drop 1 from E160)
    wait_valid(40, n);
    chk("p4_latency", n, 1);
    get_pkt(-1);
    chk("p4_w0", pkt[0], 32'h0004_010B);
    chk("p4_w1", pkt[1], 32'd168);
    chk("p4_last_pos", last_pos, 23);
    chk("final_active", 32'(active), 32'd0);
    bad = 0;
    repeat (40) begin
      step(1);
      if (tx_if.tx_valid || active) bad++;
    end
    chk("idle_after_final", bad, 0);

    // Disable coincident with the first tick -> one final packet
    csr_write(12'h320, 32'h0000_0000);
    step(15);
    csr_we   = 1'b1;
    csr_add  = 12'h320;
    csr_data = 32'hFFFF_FFFF;
    step(1);
    csr_we   = 1'b0;
    chk("coinc_valid", 32'(tx_if.tx_valid), 32'd1);
    get_pkt(-1);
    chk("coinc_w0", pkt[0], 32'h0005_000B);
    chk("coinc_w1", pkt[1], 32'd15);
    chk("coinc_active", 32'(active), 32'd0);
    bad = 0;
    repeat (40) begin
      step(1);
      if (tx_if.tx_valid) bad++;
    end
    chk("coinc_no_more", bad, 0);

    // Reset mid-packet at word 10
    csr_write(12'h320, 32'h0000_0000);
    wait_valid(40, n);
    chk("g_latency", n, 16);
    step(10);
    chk("g_valid_w10", 32'(tx_if.tx_valid), 32'd1);
    rst_h = 1'b0;
    #1;
    chk("arst_valid", 32'(tx_if.tx_valid), 32'd0);
    chk("arst_data", tx_if.tx_data, 32'd0);
    chk("arst_active", 32'(active), 32'd0);
    step(2);
    rst_h = 1'b1;
    step(1);

    // Re-enable, seq restarts at 0; hold packet long enough to saturate drops
    tx_if.tx_ready = 1'b0;
    csr_write(12'h320, 32'h0000_0000);
    wait_valid(40, n);
    chk("h_latency", n, 16);
    chk("h_stalled_w0", tx_if.tx_data, 32'h0000_000B);
    hold = tx_if.tx_data;
    bad  = 0;
    repeat (4200) begin
      step(1);
      if (!tx_if.tx_valid || tx_if.tx_data !== hold) bad++;
    end
    chk("long_stall_stable", bad, 0);
    chk("sat_set", 32'(dropped_sat), 32'd1);
    get_pkt(-1);
    chk("h_w0", pkt[0], 32'h0000_000B);
    chk("h_w1", pkt[1], 32'd15);
    chk("h_nlast", nlast, 1);
    chk("h_last_pos", last_pos, 23);
    chk("sat_hold", 32'(dropped_sat), 32'd1);
    wait_valid(40, n);
    chk("h1_latency", n, 16);
    get_pkt(-1);
    chk("h1_w0_sat", pkt[0], 32'h0001_FF0B);
    chk("sat_cleared", 32'(dropped_sat), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
